pixel_unpacker: RTL and testbench

//  AXI4-Stream video sink: the receive end of the packed RGB pixel stream that the pixel generator/packer emits.

---
 rtl/pixel_unpacker.sv | 268 ++++++++++++++++++++++++++
 tb/tb_pixel_unpacker.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_unpacker.sv
// pixel_unpacker
//   AXI4-Stream video sink. Receives packed RGB words (three 32-bit words
//   carry four 24-bit pixels, bytes consumed LSB first, R,G,B order),
//   re-frames them into one pixel per handshake with x/y coordinates, and
//   checks the stream framing (tuser = start of frame, tlast = end of line).
//
// Parameters
//   X_SIZE  pixels per line (multiple of 4 so every line is word aligned)
//   Y_SIZE  lines per frame
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   in_stream_t*             AXI4-Stream slave (tkeep is ignored)
//   r, g, b, x, y, sof, eol  registered output pixel and its position
//   pixel_valid/pixel_ready  output handshake
//   err_sof, err_eol         one-cycle framing error pulses
//   frame_count              completed output frames, wraps at 16 bits
//
// Optional feature (macro FRAME_CHECKSUM_EN)
//   frame_sum        running sum of {8'h0,R,G,B} over the current frame
//   frame_sum_valid  one-cycle pulse when frame_count increments
module pixel_unpacker #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        sof,
  output logic        eol,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        err_sof,
  output logic        err_eol,
  output logic [15:0] frame_count
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [31:0] frame_sum,
  output logic        frame_sum_valid
`endif
);

  localparam logic [15:0] WX_LAST = 16'(3 * X_SIZE / 4 - 1);
  localparam logic [15:0] WY_LAST = 16'(Y_SIZE - 1);
  localparam logic [15:0] X_LAST  = 16'(X_SIZE - 1);
  localparam logic [15:0] Y_LAST  = 16'(Y_SIZE - 1);

  typedef enum logic {HUNT, ACTIVE} state_t;

  state_t      state_q, state_d;
  // Byte FIFO kept as a 48-bit vector: byte 0 (oldest) in bits [7:0].
  // Bytes above bc are always zero, so appending is a simple OR.
  logic [47:0] fifo_q, fifo_d;
  logic [2:0]  bc_q, bc_d;
  logic [15:0] wx_q, wx_d, wy_q, wy_d;
  logic [15:0] nx_q, nx_d, ny_q, ny_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic        sof_q, sof_d, eol_q, eol_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic        err_sof_q, err_sof_d, err_eol_q, err_eol_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic        accept, load, handshake, last_pix, at_origin;
  logic        keep, flush, start;
  logic [15:0] word_pos, line_pos;
  logic [2:0]  bc_base;
  logic        unused_tkeep;

  assign unused_tkeep     = ^in_stream_tkeep;
  assign in_stream_tready = (bc_q <= 3'd2) && aresetn;
  assign accept           = in_stream_tvalid && in_stream_tready;
  assign load             = (!pixel_valid_q || pixel_ready) && (bc_q >= 3'd3);
  assign handshake        = pixel_valid_q && pixel_ready;
  assign last_pix         = handshake && (x_q == X_LAST) && (y_q == Y_LAST);
  assign at_origin        = (wx_q == 16'd0) && (wy_q == 16'd0);

  always_comb begin
    state_d       = state_q;
    fifo_d        = fifo_q;
    bc_d          = bc_q;
    wx_d          = wx_q;
    wy_d          = wy_q;
    nx_d          = nx_q;
    ny_d          = ny_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    x_d           = x_q;
    y_d           = y_q;
    sof_d         = sof_q;
    eol_d         = eol_q;
    pixel_valid_d = pixel_valid_q;
    err_sof_d     = 1'b0;
    err_eol_d     = 1'b0;
    frame_count_d = frame_count_q;
    keep          = 1'b0;
    flush         = 1'b0;
    start         = 1'b0;

    // Framing decision for an accepted word: keep it, keep it as word 0
    // of a new frame (optionally flushing leftovers), or drop it.
    if (accept) begin
      case (state_q)
        HUNT: begin
          if (in_stream_tuser) begin
            keep    = 1'b1;
            start   = 1'b1;
            state_d = ACTIVE;
          end
        end
        default: begin
          if (in_stream_tuser && !at_origin) begin
            err_sof_d = 1'b1;
            keep      = 1'b1;
            start     = 1'b1;
            flush     = 1'b1;
          end else if (!in_stream_tuser && at_origin) begin
            err_sof_d = 1'b1;
            state_d   = HUNT;
          end else begin
            keep = 1'b1;
          end
        end
      endcase
    end

    word_pos = start ? 16'd0 : wx_q;
    line_pos = start ? 16'd0 : wy_q;
    bc_base  = flush ? 3'd0 : bc_q;

    // A word is only accepted with bc<=2 and a pixel only loads with bc>=3,
    // so append and pop never collide on the same edge.
    if (keep) begin
      err_eol_d = in_stream_tlast != (word_pos == WX_LAST);
      if (word_pos == WX_LAST) begin
        wx_d = 16'd0;
        wy_d = (line_pos == WY_LAST) ? 16'd0 : line_pos + 16'd1;
      end else begin
        wx_d = word_pos + 16'd1;
        wy_d = line_pos;
      end
      fifo_d = (flush ? 48'd0 : fifo_q) | ({16'd0, in_stream_tdata} << {bc_base, 3'b000});
      bc_d   = bc_base + 3'd4;
      if (start) begin
        nx_d = 16'd0;
        ny_d = 16'd0;
      end
    end else if (load) begin
      fifo_d        = fifo_q >> 24;
      bc_d          = bc_q - 3'd3;
      r_d           = fifo_q[7:0];
      g_d           = fifo_q[15:8];
      b_d           = fifo_q[23:16];
      x_d           = nx_q;
      y_d           = ny_q;
      sof_d         = (nx_q == 16'd0) && (ny_q == 16'd0);
      eol_d         = (nx_q == X_LAST);
      pixel_valid_d = 1'b1;
      if (nx_q == X_LAST) begin
        nx_d = 16'd0;
        ny_d = (ny_q == Y_LAST) ? 16'd0 : ny_q + 16'd1;
      end else begin
        nx_d = nx_q + 16'd1;
      end
    end

    if (!load && handshake) begin
      pixel_valid_d = 1'b0;
    end

    if (last_pix) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= HUNT;
      fifo_q        <= '0;
      bc_q          <= '0;
      wx_q          <= '0;
      wy_q          <= '0;
      nx_q          <= '0;
      ny_q          <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      sof_q         <= 1'b0;
      eol_q         <= 1'b0;
      pixel_valid_q <= 1'b0;
      err_sof_q     <= 1'b0;
      err_eol_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fifo_q        <= fifo_d;
      bc_q          <= bc_d;
      wx_q          <= wx_d;
      wy_q          <= wy_d;
      nx_q          <= nx_d;
      ny_q          <= ny_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      x_q           <= x_d;
      y_q           <= y_d;
      sof_q         <= sof_d;
      eol_q         <= eol_d;
      pixel_valid_q <= pixel_valid_d;
      err_sof_q     <= err_sof_d;
      err_eol_q     <= err_eol_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign x           = x_q;
  assign y           = y_q;
  assign sof         = sof_q;
  assign eol         = eol_q;
  assign pixel_valid = pixel_valid_q;
  assign err_sof     = err_sof_q;
  assign err_eol     = err_eol_q;
  assign frame_count = frame_count_q;

`ifdef FRAME_CHECKSUM_EN
  logic [31:0] frame_sum_q, frame_sum_d;
  logic        frame_sum_valid_q, frame_sum_valid_d;

  // The (0,0) pixel restarts the sum with its own value.
  always_comb begin
    frame_sum_d       = frame_sum_q;
    frame_sum_valid_d = last_pix;
    if (handshake) begin
      frame_sum_d = (sof_q ? 32'd0 : frame_sum_q) + {8'h0, r_q, g_q, b_q};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_sum_q       <= '0;
      frame_sum_valid_q <= 1'b0;
    end else begin
      frame_sum_q       <= frame_sum_d;
      frame_sum_valid_q <= frame_sum_valid_d;
    end
  end

  assign frame_sum       = frame_sum_q;
  assign frame_sum_valid = frame_sum_valid_q;
`endif

endmodule

// File: tb/tb_pixel_unpacker.sv
// tb_pixel_unpacker
//   Self-checking bench for pixel_unpacker with an 8x2 frame (6 words per
//   line, 12 words and 16 pixels per frame). A queue-based reference model
//   derives the expected pixel stream and error counts from the word list.
module tb_pixel_unpacker;

  localparam int XS          = 8;
  localparam int YS          = 2;
  localparam int WPL         = 3 * XS / 4;
  localparam int FRAME_WORDS = WPL * YS;

  typedef struct packed {
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [15:0] x;
    logic [15:0] y;
    logic        sof;
    logic        eol;
  } pix_t;

  typedef struct packed {
    logic [31:0] data;
    logic        user;
    logic        last;
  } word_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] in_stream_tdata;
  logic [3:0]  in_stream_tkeep;
  logic        in_stream_tlast;
  logic        in_stream_tuser;
  logic        in_stream_tvalid;
  logic        in_stream_tready;
  logic [7:0]  r, g, b;
  logic [15:0] x, y;
  logic        sof, eol;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        err_sof, err_eol;
  logic [15:0] frame_count;
`ifdef FRAME_CHECKSUM_EN
  logic [31:0] frame_sum;
  logic        frame_sum_valid;
`endif

  always #5 aclk = ~aclk;

  pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .in_stream_tdata  (in_stream_tdata),
    .in_stream_tkeep  (in_stream_tkeep),
    .in_stream_tlast  (in_stream_tlast),
    .in_stream_tuser  (in_stream_tuser),
    .in_stream_tvalid (in_stream_tvalid),
    .in_stream_tready (in_stream_tready),
    .r                (r),
    .g                (g),
    .b                (b),
    .x                (x),
    .y                (y),
    .sof              (sof),
    .eol              (eol),
    .pixel_valid      (pixel_valid),
    .pixel_ready      (pixel_ready),
    .err_sof          (err_sof),
    .err_eol          (err_eol),
    .frame_count      (frame_count)
`ifdef FRAME_CHECKSUM_EN
    ,
    .frame_sum        (frame_sum),
    .frame_sum_valid  (frame_sum_valid)
`endif
  );

  int checks = 0;
  int errors = 0;

  word_t      wq[$];
  pix_t       exp_q[$];
  pix_t       got_q[$];
  logic [7:0] m_bytes[$];
  bit         m_hunt;
  int         m_pos, m_n;
  int         exp_esof, exp_eol, exp_frames;
  logic [31:0] m_sum, exp_sum;

  int          got_esof, got_eol, stab_err, sum_pulses, coin_err;
  bit          saw_tready_low;
  logic [31:0] got_sum;
  bit          prev_hold;
  pix_t        prev_pix;
  logic [15:0] prev_fc;

  // Output monitor: samples on the falling edge, away from DUT updates.
  always @(negedge aclk) begin
    pix_t cur;
    if (!aresetn) begin
      prev_hold = 1'b0;
      prev_fc   = '0;
    end else begin
      cur = {r, g, b, x, y, sof, eol};
      if (pixel_valid && pixel_ready) got_q.push_back(cur);
      if (err_sof) got_esof++;
      if (err_eol) got_eol++;
      if (!in_stream_tready) saw_tready_low = 1'b1;
      if (prev_hold && !(pixel_valid && cur == prev_pix)) stab_err++;
      prev_hold = pixel_valid && !pixel_ready;
      prev_pix  = cur;
`ifdef FRAME_CHECKSUM_EN
      if (frame_sum_valid) begin
        sum_pulses++;
        got_sum = frame_sum;
      end
      if ((frame_count != prev_fc) != frame_sum_valid) coin_err++;
`endif
      prev_fc = frame_count;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the end of the sequence");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    m_hunt = 1'b1;
    m_pos = 0;
    m_n = 0;
    m_bytes.delete();
    exp_q.delete();
    got_q.delete();
    exp_esof = 0;
    exp_eol = 0;
    exp_frames = 0;
    m_sum = '0;
    exp_sum = '0;
    got_esof = 0;
    got_eol = 0;
    stab_err = 0;
    sum_pulses = 0;
    coin_err = 0;
    got_sum = '0;
  endtask

  // Keeps a word at frame position pos: line-end check, then every complete
  // group of three bytes becomes the next pixel in raster order.
  task automatic modelTake(input word_t w, input int pos);
    pix_t p;
    int   xx, yy;
    if (w.last !== ((pos % WPL) == WPL - 1)) exp_eol++;
    for (int j = 0; j < 4; j++) m_bytes.push_back(w.data[8*j +: 8]);
    m_pos = (pos + 1) % FRAME_WORDS;
    while (m_bytes.size() >= 3) begin
      p.r = m_bytes.pop_front();
      p.g = m_bytes.pop_front();
      p.b = m_bytes.pop_front();
      xx = m_n % XS;
      yy = (m_n / XS) % YS;
      m_n++;
      p.x = 16'(xx);
      p.y = 16'(yy);
      p.sof = (xx == 0) && (yy == 0);
      p.eol = (xx == XS - 1);
      exp_q.push_back(p);
      if (p.sof) m_sum = '0;
      m_sum = m_sum + {8'h0, p.r, p.g, p.b};
      if (xx == XS - 1 && yy == YS - 1) begin
        exp_frames++;
        exp_sum = m_sum;
      end
    end
  endtask

  task automatic modelWord(input word_t w);
    if (m_hunt) begin
      if (w.user) begin
        m_hunt = 1'b0;
        m_bytes.delete();
        m_n = 0;
        modelTake(w, 0);
      end
    end else if (w.user && m_pos != 0) begin
      exp_esof++;
      m_bytes.delete();
      m_n = 0;
      modelTake(w, 0);
    end else if (!w.user && m_pos == 0) begin
      exp_esof++;
      m_hunt = 1'b1;
    end else begin
      modelTake(w, m_pos);
    end
  endtask

  task automatic pushWord(input logic [31:0] d, input logic u, input logic l);
    word_t w;
    w.data = d;
    w.user = u;
    w.last = l;
    wq.push_back(w);
  endtask

  // kind 0: byte ramp 11,22,33..; kind 1: random; kind 2: repeating 01,02,03
  task automatic buildFrame(input int kind);
    logic [31:0] d;
    int k;
    for (int i = 0; i < FRAME_WORDS; i++) begin
      for (int j = 0; j < 4; j++) begin
        k = 4 * i + j;
        case (kind)
          0:       d[8*j +: 8] = 8'((k + 1) * 17);
          1:       d[8*j +: 8] = 8'($urandom_range(0, 255));
          default: d[8*j +: 8] = 8'(k % 3 + 1);
        endcase
      end
      pushWord(d, i == 0, (i % WPL) == WPL - 1);
    end
  endtask

  // mode 0: always ready; mode 1: ready low for 10 cycles; mode 2: random
  // ready and random valid gaps. Returns one cycle after an active edge.
  task automatic applyStimulus(input int mode, input bit drain);
    int i = 0;
    int cyc = 0;
    bit acc;
    foreach (wq[k]) modelWord(wq[k]);
    @(posedge aclk);
    #1;
    while (i < wq.size() && cyc < 3000) begin
      in_stream_tvalid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_stream_tdata  = wq[i].data;
      in_stream_tuser  = wq[i].user;
      in_stream_tlast  = wq[i].last;
      case (mode)
        1:       pixel_ready = !(cyc >= 2 && cyc < 12);
        2:       pixel_ready = ($urandom_range(0, 2) != 0);
        default: pixel_ready = 1'b1;
      endcase
      acc = in_stream_tvalid && in_stream_tready;
      @(posedge aclk);
      #1;
      if (acc) i++;
      cyc++;
    end
    in_stream_tvalid = 1'b0;
    in_stream_tuser  = 1'b0;
    in_stream_tlast  = 1'b0;
    checkOutput("words_accepted", i, wq.size());
    wq.delete();
    if (drain) begin
      pixel_ready = 1'b1;
      repeat (30) @(posedge aclk);
      #1;
    end
  endtask

  task automatic checkFrame(input string tag);
    int n;
    checkOutput({tag, "_pix_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) checkOutput($sformatf("%s_pix%0d", tag, i), got_q[i], exp_q[i]);
    checkOutput({tag, "_err_sof"}, got_esof, exp_esof);
    checkOutput({tag, "_err_eol"}, got_eol, exp_eol);
    checkOutput({tag, "_frame_count"}, frame_count, 16'(exp_frames));
    checkOutput({tag, "_hold_stable"}, stab_err, 0);
`ifdef FRAME_CHECKSUM_EN
    checkOutput({tag, "_sum_pulses"}, sum_pulses, exp_frames);
    checkOutput({tag, "_sum_coincide"}, coin_err, 0);
    if (exp_frames > 0) checkOutput({tag, "_frame_sum"}, got_sum, exp_sum);
`endif
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_pixel"}, {r, g, b, x, y, sof, eol}, 64'd0);
    checkOutput({tag, "_ctrl"}, {pixel_valid, err_sof, err_eol, frame_count}, 64'd0);
`ifdef FRAME_CHECKSUM_EN
    checkOutput({tag, "_sum"}, {frame_sum_valid, frame_sum}, 64'd0);
`endif
  endtask

  initial begin
    word_t w0;
    aresetn          = 1'b0;
    in_stream_tdata  = '0;
    in_stream_tkeep  = 4'hF;
    in_stream_tlast  = 1'b0;
    in_stream_tuser  = 1'b0;
    in_stream_tvalid = 1'b0;
    pixel_ready      = 1'b0;
    modelReset();

    // Power-on reset state
    #3;
    checkResetOutputs("por");
    #20;
    aresetn = 1'b1;
    #1;
    checkOutput("por_tready", in_stream_tready, 1);

    // Ramp frame, always ready
    $display("[TB] ramp frame");
    buildFrame(0);
    applyStimulus(0, 1);
    checkOutput("ramp_first_r", 0, 0 + (exp_frames != 1));
    checkFrame("ramp");

    // Same frame with a 10-cycle downstream stall
    $display("[TB] stalled frame");
    saw_tready_low = 1'b0;
    buildFrame(0);
    applyStimulus(1, 1);
    checkOutput("stall_tready_low", saw_tready_low, 1);
    checkFrame("stall");

    // Reset in the middle of a frame
    $display("[TB] mid-stream reset");
    buildFrame(0);
    wq = wq[0:4];
    applyStimulus(0, 0);
    #2;
    aresetn = 1'b0;
    #1;
    checkResetOutputs("midrst");
    modelReset();
    repeat (2) @(posedge aclk);
    #2;
    aresetn = 1'b1;
    #1;
    checkOutput("midrst_tready", in_stream_tready, 1);

    // Words without tuser in HUNT are dropped silently
    $display("[TB] hunt discard");
    pushWord(32'hDEAD0001, 1'b0, 1'b0);
    pushWord(32'hDEAD0002, 1'b0, 1'b0);
    pushWord(32'hDEAD0003, 1'b0, 1'b1);
    applyStimulus(0, 1);
    checkOutput("hunt_no_pixels", got_q.size(), 0);
    checkOutput("hunt_no_err", got_esof + got_eol, 0);

    // First word of the frame: pixel appears one edge after acceptance
    buildFrame(1);
    w0 = wq.pop_front();
    modelWord(w0);
    @(posedge aclk);
    #1;
    in_stream_tvalid = 1'b1;
    in_stream_tdata  = w0.data;
    in_stream_tuser  = w0.user;
    in_stream_tlast  = w0.last;
    pixel_ready      = 1'b1;
    checkOutput("lat_tready", in_stream_tready, 1);
    @(posedge aclk);
    #1;
    in_stream_tvalid = 1'b0;
    in_stream_tuser  = 1'b0;
    checkOutput("lat_not_yet", pixel_valid, 0);
    @(posedge aclk);
    #1;
    checkOutput("lat_valid", pixel_valid, 1);
    checkOutput("lat_rgb", {r, g, b}, {w0.data[7:0], w0.data[15:8], w0.data[23:16]});
    applyStimulus(0, 1);
    checkFrame("hunt_frame");

    // Extra tlast on word 4, then tuser on word 7 restarting the frame
    $display("[TB] framing errors");
    buildFrame(0);
    wq = wq[0:6];
    wq[4].last = 1'b1;
    pushWord($urandom, 1'b1, 1'b0);
    for (int p = 1; p < FRAME_WORDS; p++) pushWord($urandom, 1'b0, (p % WPL) == WPL - 1);
    applyStimulus(0, 1);
    checkOutput("err_eol_once", got_eol, 1);
    checkOutput("err_sof_once", got_esof, 1);
    checkFrame("errors");

    // Random frames, random gaps and backpressure, a stray word between
    $display("[TB] random traffic");
    buildFrame(1);
    pushWord($urandom, 1'b0, 1'b0);
    buildFrame(1);
    buildFrame(1);
    applyStimulus(2, 1);
    checkFrame("random");

`ifdef FRAME_CHECKSUM_EN
    // Constant-colour frame with a known checksum
    $display("[TB] checksum frame");
    buildFrame(2);
    applyStimulus(0, 1);
    checkOutput("sum_010203", got_sum, 32'h00102030);
    checkFrame("checksum");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
